// File: rtl/traffic_req_conditioner.sv
// Input conditioner for the traffic light controller: synchronizes and debounces the
// vehicle sensors, and turns emergency requests into fixed-length, fairly arbitrated pulses.
module traffic_req_conditioner #(
   parameter int DEB_CYCLES = 4,
   parameter int EMG_HOLD   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_sa,
   input  logic       raw_sb,
   input  logic       raw_emg_a,
   input  logic       raw_emg_b,
   output logic       SA,
   output logic       SB,
   output logic       Emg_A,
   output logic       Emg_B,
   output logic       emg_busy,
   output logic [7:0] emg_count
);

   localparam logic [3:0] DEB_MAX   = 4'(DEB_CYCLES - 1);
   localparam logic [3:0] HOLD_LOAD = 4'(EMG_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD_A = 2'd1,
      HOLD_B = 2'd2
   } state_t;

   // Synchronizer bit order: 0 = sensor A, 1 = sensor B, 2 = emergency A, 3 = emergency B.
   logic [3:0] sync1_q, sync2_q;
   logic [1:0] emg_prev_q;

   logic       s_sa, s_sb, s_emg_a, s_emg_b;
   logic       rise_a, rise_b;

   logic [3:0] deb_a_q, deb_a_d;
   logic [3:0] deb_b_q, deb_b_d;
   logic       sa_q, sa_d;
   logic       sb_q, sb_d;

   state_t     state_q, state_d;
   logic [3:0] hold_q, hold_d;
   logic       pend_a_q, pend_a_d;
   logic       pend_b_q, pend_b_d;
   logic       emg_a_q, emg_a_d;
   logic       emg_b_q, emg_b_d;
   logic       busy_q, busy_d;
   logic [7:0] count_q, count_d;
   logic       enter_a, enter_b;

   assign s_sa    = sync2_q[0];
   assign s_sb    = sync2_q[1];
   assign s_emg_a = sync2_q[2];
   assign s_emg_b = sync2_q[3];

   assign rise_a  = s_emg_a & ~emg_prev_q[0];
   assign rise_b  = s_emg_b & ~emg_prev_q[1];

   // The counter only runs while the synchronized level disagrees with the output,
   // so any disagreement shorter than DEB_CYCLES is forgotten.
   always_comb begin
      deb_a_d = deb_a_q;
      sa_d    = sa_q;
      if (s_sa == sa_q) begin
         deb_a_d = 4'd0;
      end else if (deb_a_q == DEB_MAX) begin
         deb_a_d = 4'd0;
         sa_d    = ~sa_q;
      end else begin
         deb_a_d = deb_a_q + 4'd1;
      end
   end

   always_comb begin
      deb_b_d = deb_b_q;
      sb_d    = sb_q;
      if (s_sb == sb_q) begin
         deb_b_d = 4'd0;
      end else if (deb_b_q == DEB_MAX) begin
         deb_b_d = 4'd0;
         sb_d    = ~sb_q;
      end else begin
         deb_b_d = deb_b_q + 4'd1;
      end
   end

   // Arbiter: decisions use the registered pend flags; on exit the other approach goes first.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      enter_a = 1'b0;
      enter_b = 1'b0;

      case (state_q)
         IDLE: begin
            if (pend_a_q) begin
               enter_a = 1'b1;
            end else if (pend_b_q) begin
               enter_b = 1'b1;
            end
         end
         HOLD_A: begin
            if (hold_q == 4'd0) begin
               if (pend_b_q) begin
                  enter_b = 1'b1;
               end else if (pend_a_q) begin
                  enter_a = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               hold_d = hold_q - 4'd1;
            end
         end
         HOLD_B: begin
            if (hold_q == 4'd0) begin
               if (pend_a_q) begin
                  enter_a = 1'b1;
               end else if (pend_b_q) begin
                  enter_b = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               hold_d = hold_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A request edge landing on the entry edge is covered by the pulse starting now.
      pend_a_d = (pend_a_q | rise_a) & ~enter_a;
      pend_b_d = (pend_b_q | rise_b) & ~enter_b;

      if (enter_a) begin
         state_d = HOLD_A;
         hold_d  = HOLD_LOAD;
      end else if (enter_b) begin
         state_d = HOLD_B;
         hold_d  = HOLD_LOAD;
      end

      count_d = count_q;
      if ((enter_a || enter_b) && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end

      emg_a_d = (state_d == HOLD_A);
      emg_b_d = (state_d == HOLD_B);
      busy_d  = (state_d != IDLE) | pend_a_d | pend_b_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q    <= 4'd0;
         sync2_q    <= 4'd0;
         emg_prev_q <= 2'd0;
         deb_a_q    <= 4'd0;
         deb_b_q    <= 4'd0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         state_q    <= IDLE;
         hold_q     <= 4'd0;
         pend_a_q   <= 1'b0;
         pend_b_q   <= 1'b0;
         emg_a_q    <= 1'b0;
         emg_b_q    <= 1'b0;
         busy_q     <= 1'b0;
         count_q    <= 8'd0;
      end else begin
         sync1_q    <= {raw_emg_b, raw_emg_a, raw_sb, raw_sa};
         sync2_q    <= sync1_q;
         emg_prev_q <= {s_emg_b, s_emg_a};
         deb_a_q    <= deb_a_d;
         deb_b_q    <= deb_b_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         state_q    <= state_d;
         hold_q     <= hold_d;
         pend_a_q   <= pend_a_d;
         pend_b_q   <= pend_b_d;
         emg_a_q    <= emg_a_d;
         emg_b_q    <= emg_b_d;
         busy_q     <= busy_d;
         count_q    <= count_d;
      end
   end

   assign SA        = sa_q;
   assign SB        = sb_q;
   assign Emg_A     = emg_a_q;
   assign Emg_B     = emg_b_q;
   assign emg_busy  = busy_q;
   assign emg_count = count_q;

endmodule

// File: tb/tb_traffic_req_conditioner.sv
// Directed bench for traffic_req_conditioner at default parameters: vector table for the
// sensor/emergency timeline plus hand sequences for arbitration and reset corners.
module tb_traffic_req_conditioner;

   logic       clk;
   logic       rst;
   logic       raw_sa, raw_sb, raw_emg_a, raw_emg_b;
   logic       SA, SB, Emg_A, Emg_B, emg_busy;
   logic [7:0] emg_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       sa, sb, ea, eb;
      logic [4:0] flags;   // {SA, SB, Emg_A, Emg_B, emg_busy}
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[$];

   traffic_req_conditioner dut (
      .clk       (clk),
      .rst       (rst),
      .raw_sa    (raw_sa),
      .raw_sb    (raw_sb),
      .raw_emg_a (raw_emg_a),
      .raw_emg_b (raw_emg_b),
      .SA        (SA),
      .SB        (SB),
      .Emg_A     (Emg_A),
      .Emg_B     (Emg_B),
      .emg_busy  (emg_busy),
      .emg_count (emg_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic set_raw(input logic sa, input logic sb, input logic ea, input logic eb);
      raw_sa    = sa;
      raw_sb    = sb;
      raw_emg_a = ea;
      raw_emg_b = eb;
   endtask

   task automatic do_reset();
      set_raw(0, 0, 0, 0);
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      repeat (4) tick();
   endtask

   task automatic add(input logic sa, input logic sb, input logic ea, input logic eb,
                      input logic [4:0] flags, input logic [7:0] cnt);
      vec_t v;
      v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb;
      v.flags = flags; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   initial begin
      // Timeline: sensor-A glitch, sensor-A hold, single Emg_B pulse, sensor-B glitch, SA release.
      add(1,0,0,0, 5'b00000, 0);
      add(1,0,0,0, 5'b00000, 0);
      for (int i = 0; i < 4; i++) add(0,0,0,0, 5'b00000, 0);
      for (int i = 0; i < 5; i++) add(1,0,0,0, 5'b00000, 0);
      add(1,0,0,0, 5'b10000, 0);
      add(1,0,0,1, 5'b10000, 0);
      add(1,0,0,0, 5'b10000, 0);
      add(1,0,0,0, 5'b10001, 0);
      for (int i = 0; i < 3; i++) add(1,0,0,0, 5'b10011, 1);
      add(1,0,0,0, 5'b10000, 1);
      add(1,0,0,0, 5'b10000, 1);
      for (int i = 0; i < 3; i++) add(0,1,0,0, 5'b10000, 1);
      add(0,0,0,0, 5'b10000, 1);
      add(0,0,0,0, 5'b10000, 1);
      add(0,0,0,0, 5'b00000, 1);
      add(0,0,0,0, 5'b00000, 1);

      // Reset with all raw inputs high, then release.
      set_raw(1, 1, 1, 1);
      rst = 1'b0;
      #2;
      chk("reset_async_outputs", {SA, SB, Emg_A, Emg_B, emg_busy, emg_count}, 13'd0);
      repeat (3) tick();
      chk("reset_held_outputs", {SA, SB, Emg_A, Emg_B, emg_busy, emg_count}, 13'd0);
      rst = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         chk($sformatf("release_sensors_e%0d", e), {SA, SB}, (e >= 6) ? 2'b11 : 2'b00);
         chk($sformatf("release_emg_a_e%0d", e), Emg_A, (e >= 4 && e <= 6) ? 1 : 0);
      end
      chk("release_emg_b_follows", Emg_B, 1);
      chk("release_count", emg_count, 2);

      // Table-driven timeline.
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         set_raw(tbl[i].sa, tbl[i].sb, tbl[i].ea, tbl[i].eb);
         tick();
         chk($sformatf("tbl%0d_flags", i), {SA, SB, Emg_A, Emg_B, emg_busy}, tbl[i].flags);
         chk($sformatf("tbl%0d_count", i), emg_count, tbl[i].cnt);
      end

      // Simultaneous requests: A first, B adjacent, never overlapping.
      do_reset();
      for (int e = 0; e < 11; e++) begin
         set_raw(0, 0, e == 0, e == 0);
         tick();
         chk($sformatf("simul_emg_e%0d", e), {Emg_A, Emg_B},
             {(e >= 3 && e <= 5) ? 1'b1 : 1'b0, (e >= 6 && e <= 8) ? 1'b1 : 1'b0});
      end
      chk("simul_count", emg_count, 2);
      chk("simul_busy_idle", emg_busy, 0);

      // Re-request during HOLD_A: second edge served back to back, third merged.
      do_reset();
      for (int e = 0; e < 12; e++) begin
         set_raw(0, 0, (e == 0) || (e == 2) || (e == 4), 0);
         tick();
         chk($sformatf("rereq_emg_e%0d", e), {Emg_A, Emg_B},
             {(e >= 3 && e <= 8) ? 1'b1 : 1'b0, 1'b0});
      end
      chk("rereq_count", emg_count, 2);
      chk("rereq_busy_idle", emg_busy, 0);

      // Reset during HOLD_B with a pending A request.
      do_reset();
      for (int e = 0; e < 5; e++) begin
         set_raw(0, 0, e == 2, e == 0);
         tick();
      end
      chk("midrst_before", {Emg_A, Emg_B, emg_busy}, 3'b011);
      rst = 1'b0;
      #1;
      chk("midrst_immediate", {Emg_A, Emg_B, emg_busy, emg_count}, 11'd0);
      tick();
      tick();
      rst = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         chk($sformatf("midrst_after_e%0d", e), {Emg_A, Emg_B, emg_busy}, 3'b000);
      end
      chk("midrst_count", emg_count, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_req_conditioner.md
TRAFFIC_REQ_CONDITIONER -- requirements
Module: traffic_req_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 4, sensor debounce length in clk cycles; legal range 1..15.
REQ-002 Parameter EMG_HOLD, default 3, emergency pulse length in clk cycles; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, release is synchronous to clk.
REQ-005 raw_sa  input  1  raw vehicle sensor, approach A; asynchronous to clk; may bounce.
REQ-006 raw_sb  input  1  raw vehicle sensor, approach B; asynchronous to clk; may bounce.
REQ-007 raw_emg_a  input  1  raw emergency request, approach A; asynchronous; level of any length.
REQ-008 raw_emg_b  input  1  raw emergency request, approach B; asynchronous; level of any length.
REQ-009 SA  output  1  debounced sensor A level, feeds the light controller.
REQ-010 SB  output  1  debounced sensor B level, feeds the light controller.
REQ-011 Emg_A  output  1  emergency pulse for approach A, exactly EMG_HOLD cycles.
REQ-012 Emg_B  output  1  emergency pulse for approach B, exactly EMG_HOLD cycles.
REQ-013 emg_busy  output  1  high while either emergency pulse is active or a request is pending.
REQ-014 emg_count  output  8  served-emergency count; saturates at 255.

Function
REQ-015 All outputs SHALL be registered; no combinational path from any raw input to any output.
REQ-016 Each raw input SHALL pass through a 2-flop synchronizer; s_x denotes the synchronized value, equal to raw_x delayed 2 edges.
REQ-017 Each sensor channel SHALL have a 4-bit debounce counter, cleared whenever s_x equals the output level.
REQ-018 While s_x differs from the output level, the counter SHALL increment each cycle; when it reaches DEB_CYCLES-1, the output SHALL toggle on the next edge and the counter SHALL clear.
REQ-019 Latency: a raw sensor change held stable SHALL appear on SA/SB on the (2+DEB_CYCLES)th edge after the first edge that samples it.
REQ-020 A glitch shorter than DEB_CYCLES synchronized cycles SHALL NOT change SA/SB.
REQ-021 A rising edge of s_emg_x (s_emg_x=1, previous=0) SHALL set pend_x on the next edge; a held level SHALL NOT re-trigger.
REQ-022 The arbiter FSM SHALL have three states: IDLE, HOLD_A, HOLD_B.
REQ-023 Emg_A=1 iff in HOLD_A; Emg_B=1 iff in HOLD_B; Emg_A and Emg_B SHALL never both be 1.
REQ-024 IDLE transitions: to HOLD_A if pend_a; else to HOLD_B if pend_b; else stay. A has priority.
REQ-025 On entering HOLD_x: clear pend_x, load the hold counter with EMG_HOLD-1, and increment emg_count unless it is 255.
REQ-026 In HOLD_x the hold counter SHALL decrement each cycle; at 0 the FSM SHALL exit.
REQ-027 Exit from HOLD_A: to HOLD_B if pend_b, else HOLD_A if pend_a, else IDLE. Exit from HOLD_B is symmetric. The other approach always goes first (fairness).
REQ-028 Back-to-back holds SHALL be adjacent: the outgoing Emg falls and the incoming Emg rises on the same edge.
REQ-029 A new edge on x during HOLD_x SHALL set pend_x and be served after the current pulse; a second edge while pend_x=1 SHALL be merged.
REQ-030 Latency: Emg_x SHALL rise 3 edges after the edge that first samples raw_emg_x high, provided the FSM is IDLE.
REQ-031 emg_busy SHALL equal (state≠IDLE) OR pend_a OR pend_b, registered.

Reset
REQ-032 While rst=0: SA=0, SB=0, Emg_A=0, Emg_B=0, emg_busy=0, emg_count=0, state=IDLE, and all synchronizers, edge registers, pend flags and counters are 0.
REQ-033 Reset asserted mid-hold SHALL drop Emg_x immediately and discard pending requests.
REQ-034 A raw_emg level already high at reset release SHALL register as a rising edge once synchronized.

Verification (clk period 10 ns, defaults unless stated)
REQ-035 Reset: rst=0 with all raw inputs high -> all outputs 0; release -> SA=SB=1 after 6 edges.
REQ-036 Debounce: raw_sa=1 for 2 cycles, then 0 -> SA stays 0; raw_sa=1 held -> SA=1 on the 6th edge.
REQ-037 Single emergency: raw_emg_b pulses 1 cycle -> Emg_B high for exactly 3 cycles starting 3 edges later; emg_count=1.
REQ-038 Simultaneous requests: raw_emg_a and raw_emg_b rise on the same edge -> Emg_A for 3 cycles, then Emg_B for 3 cycles with no gap; never overlap; emg_count=2.
REQ-039 Re-request during hold: a second raw_emg_a edge during HOLD_A -> second 3-cycle Emg_A pulse follows directly; a third edge during the same hold is merged.
REQ-040 Mid-operation reset: rst=0 during HOLD_B with pend_a set -> Emg_B=0 immediately; after release, no Emg_A occurs; emg_count=0.
